rv_mc_controller: RTL and testbench
===================================

Name: rv_mc_controller

Overview:
- Main control unit for the RV32 multicycle core.
- A Moore FSM sequences fetch, decode, execute, memory and writeback over the shared ALU, instruction/data memory port and register file.
- An embedded ALU decoder produces the 3-bit ALUControl consumed by the ALU. The ALU's Zero/Negative/Overflow flags drive branch resolution.
- A memory-ready handshake stalls the FSM on slow memory.

Parameters:
- OPW, 7, opcode field width.
- ACW, 3, ALUControl width. Codes: 000 add, 001 sub, 010 and, 011 or, 101 slt.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- op  in  7  instruction[6:0] from the instruction register
- funct3  in  3  instruction[14:12]
- funct7b5  in  1  instruction[30]
- Zero  in  1  ALU zero flag
- Negative  in  1  ALU negative flag
- Overflow  in  1  ALU overflow flag
- mem_ready  in  1  memory access completes this cycle
- PCWrite  out  1  PC register enable
- AdrSrc  out  1  memory address: 0 = PC, 1 = ALUOut
- MemWrite  out  1  memory write strobe
- IRWrite  out  1  instruction register and OldPC enable
- RegWrite  out  1  register file write enable
- ResultSrc  out  2  00 ALUOut, 01 Data, 10 ALUResult
- ALUSrcA  out  2  00 PC, 01 OldPC, 10 A (rs1)
- ALUSrcB  out  2  00 B (rs2), 01 ImmExt, 10 constant 4
- ImmSrc  out  2  00 I, 01 S, 10 B, 11 J; combinational from op
- ALUControl  out  3  ALU operation select
- instr_retired  out  1  one-cycle pulse on instruction completion
- illegal_instr  out  1  one-cycle pulse on an unsupported encoding
- state_dbg  out  4  current state encoding

Behaviour:
- Reset: asynchronous, active-low; state goes to FETCH. While rst_n = 0, PCWrite, IRWrite, MemWrite, RegWrite, instr_retired and illegal_instr are forced to 0. The other outputs take their FETCH values.
- Outputs are combinational from the state, gated by mem_ready and branch-taken where stated below. Unlisted outputs are 0; unlisted ALUControl is add.
- FETCH: AdrSrc = 0, ALUSrcA = 00, ALUSrcB = 10, add, ResultSrc = 10.
  - IRWrite = PCWrite = mem_ready.
  - Stay in FETCH while mem_ready = 0; go to DECODE when it is 1.
- DECODE: ALUSrcA = 01, ALUSrcB = 01, add (branch/jump target lands in ALUOut). Next state by op:
  - 0000011 or 0100011 -> MEMADR
  - 0110011 -> EXECR
  - 0010011 -> EXECI
  - 1101111 -> JAL
  - 1100011 -> BRANCH
  - anything else -> FETCH with an illegal_instr pulse.
- MEMADR: ALUSrcA = 10, ALUSrcB = 01, add. Next state: MEMREAD for load, MEMWRITE for store.
- MEMREAD: AdrSrc = 1, ResultSrc = 00. Hold until mem_ready, then MEMWB.
- MEMWB: ResultSrc = 01, RegWrite = 1, instr_retired = 1. Next: FETCH.
- MEMWRITE: AdrSrc = 1, ResultSrc = 00, MemWrite = 1 held until mem_ready. Exit to FETCH with instr_retired = 1 in the mem_ready cycle.
- EXECR: ALUSrcA = 10, ALUSrcB = 00, ALUControl from the decoder. Next: ALUWB.
- EXECI: ALUSrcA = 10, ALUSrcB = 01, ALUControl from the decoder. Next: ALUWB.
- ALUWB: ResultSrc = 00, RegWrite = 1, instr_retired = 1. Next: FETCH.
- JAL: ALUSrcA = 01, ALUSrcB = 10, add, ResultSrc = 00, PCWrite = 1 (PC <- target, ALU computes PC+4). Next: ALUWB.
- BRANCH: ALUSrcA = 10, ALUSrcB = 00, sub, ResultSrc = 00, PCWrite = taken, instr_retired = 1. Next: FETCH. taken by funct3:
  - 000: Zero
  - 001: ~Zero
  - 100: Negative ^ Overflow
  - 101: ~(Negative ^ Overflow)
  - other: 0, with an illegal_instr pulse
- ALU decoder:
  - funct3 000: sub if op = R-type and funct7b5 = 1, otherwise add (I-type ignores funct7b5).
  - funct3 010: slt (101).
  - funct3 110: or (011).
  - funct3 111: and (010).
  - Other funct3 in EXECR/EXECI: add, with an illegal_instr pulse. Writeback still occurs.
- A mem_ready change mid-wait has no effect on other outputs. Reset asserted in any state aborts the instruction and squashes all strobes immediately.
- Cycle counts with mem_ready held high:
  - load: 5
  - store: 4
  - R/I: 4
  - jal: 4
  - branch: 3

Decomposition:
- Package rv_mc_pkg:
  - state enum: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, JAL, BRANCH
  - opcode constants
  - ALUControl codes
  - ResultSrc/ALUSrc/ImmSrc encodings
- Sub-module: rv_alu_decoder (combinational: op, funct3, funct7b5 -> ALUControl, illegal).
- FSM, branch logic and output decode stay in the top module.

Test Plan:
- Reset with mem_ready = 1, rst_n low for 3 cycles -> all strobes 0, state_dbg = FETCH. First cycle after release: IRWrite = PCWrite = 1.
- add x3,x1,x2 (op 0110011, funct3 000, funct7b5 0), mem_ready = 1 -> FETCH, DECODE, EXECR (ALUControl = 000, SrcA = 10, SrcB = 00), ALUWB (RegWrite = 1, instr_retired = 1). 4 cycles. Repeat with funct7b5 = 1 -> ALUControl = 001.
- lw with mem_ready low for 3 cycles in MEMREAD -> state held, RegWrite = 0. After mem_ready rises: MEMWB with RegWrite = 1, ResultSrc = 01.
- beq with Zero = 1 -> PCWrite = 1 in BRANCH, ALUControl = 001. bne with Zero = 1 -> PCWrite = 0. blt with Negative = 1, Overflow = 1 -> not taken.
- sw with mem_ready = 0 for 2 cycles -> MemWrite = 1 for 3 cycles, AdrSrc = 1, then FETCH. slti (funct3 010) -> ALUControl = 101.
- op = 1111111 -> DECODE to FETCH with illegal_instr pulse, no RegWrite/MemWrite. rst_n pulsed low during MEMWRITE -> MemWrite drops asynchronously and state returns to FETCH.

Source files
------------

// File: rtl/rv_mc_pkg.sv
// Shared types and encodings for the RV32 multicycle control unit.
package rv_mc_pkg;

  localparam int unsigned OPW = 7;
  localparam int unsigned ACW = 3;

  typedef enum logic [3:0] {
    StFetch    = 4'd0,
    StDecode   = 4'd1,
    StMemAdr   = 4'd2,
    StMemRead  = 4'd3,
    StMemWb    = 4'd4,
    StMemWrite = 4'd5,
    StExecR    = 4'd6,
    StExecI    = 4'd7,
    StAluWb    = 4'd8,
    StJal      = 4'd9,
    StBranch   = 4'd10
  } state_e;

  localparam logic [OPW-1:0] OpLoad   = 7'b0000011;
  localparam logic [OPW-1:0] OpStore  = 7'b0100011;
  localparam logic [OPW-1:0] OpRType  = 7'b0110011;
  localparam logic [OPW-1:0] OpIType  = 7'b0010011;
  localparam logic [OPW-1:0] OpJal    = 7'b1101111;
  localparam logic [OPW-1:0] OpBranch = 7'b1100011;

  localparam logic [ACW-1:0] AluAdd = 3'b000;
  localparam logic [ACW-1:0] AluSub = 3'b001;
  localparam logic [ACW-1:0] AluAnd = 3'b010;
  localparam logic [ACW-1:0] AluOr  = 3'b011;
  localparam logic [ACW-1:0] AluSlt = 3'b101;

  localparam logic [1:0] ResAluOut    = 2'b00;
  localparam logic [1:0] ResData      = 2'b01;
  localparam logic [1:0] ResAluResult = 2'b10;

  localparam logic [1:0] SrcAPc    = 2'b00;
  localparam logic [1:0] SrcAOldPc = 2'b01;
  localparam logic [1:0] SrcARs1   = 2'b10;

  localparam logic [1:0] SrcBRs2  = 2'b00;
  localparam logic [1:0] SrcBImm  = 2'b01;
  localparam logic [1:0] SrcBFour = 2'b10;

  localparam logic [1:0] ImmI = 2'b00;
  localparam logic [1:0] ImmS = 2'b01;
  localparam logic [1:0] ImmB = 2'b10;
  localparam logic [1:0] ImmJ = 2'b11;

endpackage

// File: rtl/rv_alu_decoder.sv
// Maps op/funct3/funct7b5 to the ALU operation; flags funct3 values the ALU does not support.
module rv_alu_decoder
  import rv_mc_pkg::*;
(
  input  logic [OPW-1:0] op_i,
  input  logic [2:0]     funct3_i,
  input  logic           funct7b5_i,
  output logic [ACW-1:0] alu_control_o,
  output logic           illegal_o
);

  always_comb begin
    alu_control_o = AluAdd;
    illegal_o     = 1'b0;
    case (funct3_i)
      // Only R-type honours funct7b5; addi with imm[10] set is still an add.
      3'b000:  alu_control_o = ((op_i == OpRType) && funct7b5_i) ? AluSub : AluAdd;
      3'b010:  alu_control_o = AluSlt;
      3'b110:  alu_control_o = AluOr;
      3'b111:  alu_control_o = AluAnd;
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/rv_mc_controller.sv
// Moore control FSM for the RV32 multicycle core: sequences fetch/decode/execute/memory/writeback.
module rv_mc_controller
  import rv_mc_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  input  logic [OPW-1:0] op,
  input  logic [2:0]     funct3,
  input  logic           funct7b5,
  input  logic           Zero,
  input  logic           Negative,
  input  logic           Overflow,
  input  logic           mem_ready,
  output logic           PCWrite,
  output logic           AdrSrc,
  output logic           MemWrite,
  output logic           IRWrite,
  output logic           RegWrite,
  output logic [1:0]     ResultSrc,
  output logic [1:0]     ALUSrcA,
  output logic [1:0]     ALUSrcB,
  output logic [1:0]     ImmSrc,
  output logic [ACW-1:0] ALUControl,
  output logic           instr_retired,
  output logic           illegal_instr,
  output logic [3:0]     state_dbg
);

  state_e state_q, state_d;

  logic [ACW-1:0] dec_alu_control;
  logic           dec_illegal;

  rv_alu_decoder u_alu_decoder (
    .op_i          (op),
    .funct3_i      (funct3),
    .funct7b5_i    (funct7b5),
    .alu_control_o (dec_alu_control),
    .illegal_o     (dec_illegal)
  );

  logic taken;
  logic branch_illegal;

  always_comb begin
    taken          = 1'b0;
    branch_illegal = 1'b0;
    case (funct3)
      3'b000:  taken = Zero;
      3'b001:  taken = ~Zero;
      3'b100:  taken = Negative ^ Overflow;
      3'b101:  taken = ~(Negative ^ Overflow);
      default: branch_illegal = 1'b1;
    endcase
  end

  always_comb begin
    case (op)
      OpStore:  ImmSrc = ImmS;
      OpBranch: ImmSrc = ImmB;
      OpJal:    ImmSrc = ImmJ;
      default:  ImmSrc = ImmI;
    endcase
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StFetch:    if (mem_ready) state_d = StDecode;
      StDecode: begin
        case (op)
          OpLoad, OpStore: state_d = StMemAdr;
          OpRType:         state_d = StExecR;
          OpIType:         state_d = StExecI;
          OpJal:           state_d = StJal;
          OpBranch:        state_d = StBranch;
          default:         state_d = StFetch;
        endcase
      end
      StMemAdr:   state_d = (op == OpLoad) ? StMemRead : StMemWrite;
      StMemRead:  if (mem_ready) state_d = StMemWb;
      StMemWb:    state_d = StFetch;
      StMemWrite: if (mem_ready) state_d = StFetch;
      StExecR:    state_d = StAluWb;
      StExecI:    state_d = StAluWb;
      StAluWb:    state_d = StFetch;
      StJal:      state_d = StAluWb;
      StBranch:   state_d = StFetch;
      default:    state_d = StFetch;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StFetch;
    end else begin
      state_q <= state_d;
    end
  end

  logic pc_write, ir_write, mem_write, reg_write, retired, illegal;
  logic op_supported;

  always_comb begin
    case (op)
      OpLoad, OpStore, OpRType, OpIType, OpJal, OpBranch: op_supported = 1'b1;
      default:                                            op_supported = 1'b0;
    endcase
  end

  always_comb begin
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    retired    = 1'b0;
    illegal    = 1'b0;
    AdrSrc     = 1'b0;
    ResultSrc  = ResAluOut;
    ALUSrcA    = SrcAPc;
    ALUSrcB    = SrcBRs2;
    ALUControl = AluAdd;
    unique case (state_q)
      StFetch: begin
        ALUSrcB   = SrcBFour;
        ResultSrc = ResAluResult;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      // Precompute the branch/jump target into ALUOut while the opcode is decoded.
      StDecode: begin
        ALUSrcA = SrcAOldPc;
        ALUSrcB = SrcBImm;
        illegal = ~op_supported;
      end
      StMemAdr: begin
        ALUSrcA = SrcARs1;
        ALUSrcB = SrcBImm;
      end
      StMemRead: AdrSrc = 1'b1;
      StMemWb: begin
        ResultSrc = ResData;
        reg_write = 1'b1;
        retired   = 1'b1;
      end
      StMemWrite: begin
        AdrSrc    = 1'b1;
        mem_write = 1'b1;
        retired   = mem_ready;
      end
      StExecR: begin
        ALUSrcA    = SrcARs1;
        ALUSrcB    = SrcBRs2;
        ALUControl = dec_alu_control;
        illegal    = dec_illegal;
      end
      StExecI: begin
        ALUSrcA    = SrcARs1;
        ALUSrcB    = SrcBImm;
        ALUControl = dec_alu_control;
        illegal    = dec_illegal;
      end
      StAluWb: begin
        reg_write = 1'b1;
        retired   = 1'b1;
      end
      StJal: begin
        ALUSrcA  = SrcAOldPc;
        ALUSrcB  = SrcBFour;
        pc_write = 1'b1;
      end
      StBranch: begin
        ALUSrcA    = SrcARs1;
        ALUSrcB    = SrcBRs2;
        ALUControl = AluSub;
        pc_write   = taken;
        retired    = 1'b1;
        illegal    = branch_illegal;
      end
      default: ;
    endcase
  end

  // Strobes are squashed combinationally so an asserted reset kills them mid-cycle.
  assign PCWrite       = rst_n & pc_write;
  assign IRWrite       = rst_n & ir_write;
  assign MemWrite      = rst_n & mem_write;
  assign RegWrite      = rst_n & reg_write;
  assign instr_retired = rst_n & retired;
  assign illegal_instr = rst_n & illegal;
  assign state_dbg     = state_q;

endmodule

// File: tb/tb_rv_mc_controller.sv
// Directed bench for rv_mc_controller: walks each instruction class through the FSM.
module tb_rv_mc_controller;

  localparam logic [3:0] SFetch = 4'd0, SDecode = 4'd1, SMemAdr = 4'd2, SMemRead = 4'd3;
  localparam logic [3:0] SMemWb = 4'd4, SMemWrite = 4'd5, SExecR = 4'd6, SExecI = 4'd7;
  localparam logic [3:0] SAluWb = 4'd8, SJal = 4'd9, SBranch = 4'd10;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5, Zero, Negative, Overflow, mem_ready;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
  logic [2:0] ALUControl;
  logic       instr_retired, illegal_instr;
  logic [3:0] state_dbg;

  int n_tests = 0;
  int n_fail  = 0;

  rv_mc_controller dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .op            (op),
    .funct3        (funct3),
    .funct7b5      (funct7b5),
    .Zero          (Zero),
    .Negative      (Negative),
    .Overflow      (Overflow),
    .mem_ready     (mem_ready),
    .PCWrite       (PCWrite),
    .AdrSrc        (AdrSrc),
    .MemWrite      (MemWrite),
    .IRWrite       (IRWrite),
    .RegWrite      (RegWrite),
    .ResultSrc     (ResultSrc),
    .ALUSrcA       (ALUSrcA),
    .ALUSrcB       (ALUSrcB),
    .ImmSrc        (ImmSrc),
    .ALUControl    (ALUControl),
    .instr_retired (instr_retired),
    .illegal_instr (illegal_instr),
    .state_dbg     (state_dbg)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0; mem_ready = 1'b1; op = 7'b0110011; funct3 = 3'b000; funct7b5 = 1'b0;
    Zero = 1'b0; Negative = 1'b0; Overflow = 1'b0;

    // Reset held for three cycles with mem_ready high
    repeat (3) tick();
    chk("rst_state", state_dbg, SFetch);
    chk("rst_pcwrite", PCWrite, 1'b0);
    chk("rst_irwrite", IRWrite, 1'b0);
    chk("rst_memwrite", MemWrite, 1'b0);
    chk("rst_regwrite", RegWrite, 1'b0);
    chk("rst_retired", instr_retired, 1'b0);
    chk("rst_srcb", ALUSrcB, 2'b10);
    chk("rst_resultsrc", ResultSrc, 2'b10);
    rst_n = 1'b1;
    #1;
    chk("fetch_irwrite", IRWrite, 1'b1);
    chk("fetch_pcwrite", PCWrite, 1'b1);

    // add x3,x1,x2
    tick();
    chk("add_decode", state_dbg, SDecode);
    chk("add_dec_srca", ALUSrcA, 2'b01);
    chk("add_dec_srcb", ALUSrcB, 2'b01);
    tick();
    chk("add_execr", state_dbg, SExecR);
    chk("add_aluctl", ALUControl, 3'b000);
    chk("add_srca", ALUSrcA, 2'b10);
    chk("add_srcb", ALUSrcB, 2'b00);
    chk("add_exec_regwrite", RegWrite, 1'b0);
    tick();
    chk("add_aluwb", state_dbg, SAluWb);
    chk("add_regwrite", RegWrite, 1'b1);
    chk("add_retired", instr_retired, 1'b1);
    tick();
    chk("add_back_fetch", state_dbg, SFetch);
    chk("add_fetch_retired", instr_retired, 1'b0);

    // sub
    funct7b5 = 1'b1;
    tick(); tick();
    chk("sub_aluctl", ALUControl, 3'b001);
    tick(); tick();

    // addi with funct7b5 set is still add
    op = 7'b0010011;
    tick(); tick();
    chk("addi_state", state_dbg, SExecI);
    chk("addi_aluctl", ALUControl, 3'b000);
    chk("addi_srcb", ALUSrcB, 2'b01);
    tick(); tick();
    funct7b5 = 1'b0;

    // lw with slow memory
    op = 7'b0000011;
    tick();
    chk("lw_immsrc", ImmSrc, 2'b00);
    tick();
    chk("lw_memadr", state_dbg, SMemAdr);
    chk("lw_memadr_srca", ALUSrcA, 2'b10);
    mem_ready = 1'b0;
    tick();
    chk("lw_memread", state_dbg, SMemRead);
    chk("lw_adrsrc", AdrSrc, 1'b1);
    tick(); tick();
    chk("lw_memread_hold", state_dbg, SMemRead);
    chk("lw_hold_regwrite", RegWrite, 1'b0);
    mem_ready = 1'b1;
    tick();
    chk("lw_memwb", state_dbg, SMemWb);
    chk("lw_regwrite", RegWrite, 1'b1);
    chk("lw_resultsrc", ResultSrc, 2'b01);
    tick();
    chk("lw_back_fetch", state_dbg, SFetch);

    // beq taken
    op = 7'b1100011; funct3 = 3'b000; Zero = 1'b1;
    tick();
    chk("beq_immsrc", ImmSrc, 2'b10);
    tick();
    chk("beq_state", state_dbg, SBranch);
    chk("beq_pcwrite", PCWrite, 1'b1);
    chk("beq_aluctl", ALUControl, 3'b001);
    chk("beq_retired", instr_retired, 1'b1);
    tick();
    chk("beq_back_fetch", state_dbg, SFetch);

    // bne with Zero=1 not taken
    funct3 = 3'b001;
    tick(); tick();
    chk("bne_pcwrite", PCWrite, 1'b0);
    tick();

    // blt with N=1,V=1 not taken
    funct3 = 3'b100; Zero = 1'b0; Negative = 1'b1; Overflow = 1'b1;
    tick(); tick();
    chk("blt_pcwrite", PCWrite, 1'b0);
    tick();

    // bge same flags -> taken
    funct3 = 3'b101;
    tick(); tick();
    chk("bge_pcwrite", PCWrite, 1'b1);
    tick();

    // unsupported branch funct3
    funct3 = 3'b010;
    tick(); tick();
    chk("bbad_illegal", illegal_instr, 1'b1);
    chk("bbad_pcwrite", PCWrite, 1'b0);
    tick();
    chk("bbad_illegal_clear", illegal_instr, 1'b0);
    Negative = 1'b0; Overflow = 1'b0;

    // sw with mem_ready low for two cycles
    op = 7'b0100011; funct3 = 3'b010;
    tick();
    chk("sw_immsrc", ImmSrc, 2'b01);
    tick();
    mem_ready = 1'b0;
    tick();
    chk("sw_memwrite_state", state_dbg, SMemWrite);
    chk("sw_memwrite1", MemWrite, 1'b1);
    chk("sw_adrsrc", AdrSrc, 1'b1);
    chk("sw_retired_wait", instr_retired, 1'b0);
    tick();
    chk("sw_memwrite2", MemWrite, 1'b1);
    mem_ready = 1'b1;
    #1;
    chk("sw_memwrite3", MemWrite, 1'b1);
    chk("sw_retired", instr_retired, 1'b1);
    tick();
    chk("sw_back_fetch", state_dbg, SFetch);
    chk("sw_memwrite_off", MemWrite, 1'b0);

    // slti
    op = 7'b0010011; funct3 = 3'b010;
    tick(); tick();
    chk("slti_aluctl", ALUControl, 3'b101);
    tick(); tick();

    // unsupported R-type funct3: illegal but writeback still happens
    op = 7'b0110011; funct3 = 3'b001;
    tick(); tick();
    chk("rbad_illegal", illegal_instr, 1'b1);
    chk("rbad_aluctl", ALUControl, 3'b000);
    tick();
    chk("rbad_regwrite", RegWrite, 1'b1);
    tick();

    // jal
    op = 7'b1101111; funct3 = 3'b000;
    tick();
    chk("jal_immsrc", ImmSrc, 2'b11);
    tick();
    chk("jal_state", state_dbg, SJal);
    chk("jal_pcwrite", PCWrite, 1'b1);
    chk("jal_srca", ALUSrcA, 2'b01);
    chk("jal_srcb", ALUSrcB, 2'b10);
    tick();
    chk("jal_aluwb", state_dbg, SAluWb);
    tick();

    // illegal opcode
    op = 7'b1111111;
    tick();
    chk("ill_illegal", illegal_instr, 1'b1);
    chk("ill_regwrite", RegWrite, 1'b0);
    chk("ill_memwrite", MemWrite, 1'b0);
    tick();
    chk("ill_back_fetch", state_dbg, SFetch);
    chk("ill_clear", illegal_instr, 1'b0);

    // reset pulsed during MEMWRITE
    op = 7'b0100011;
    tick(); tick();
    mem_ready = 1'b0;
    tick();
    chk("rstmw_memwrite_on", MemWrite, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    chk("rstmw_memwrite_off", MemWrite, 1'b0);
    chk("rstmw_state", state_dbg, SFetch);
    tick();
    rst_n = 1'b1;
    #1;
    chk("rstmw_fetch_stall_ir", IRWrite, 1'b0);
    tick();
    chk("rstmw_fetch_hold", state_dbg, SFetch);
    mem_ready = 1'b1;
    tick();
    chk("rstmw_decode", state_dbg, SDecode);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
